output_hold_shaper: RTL and testbench
=====================================

// Module: output_hold_shaper
// PURPOSE
//  Output-side counterpart of the input debounce filter. Drives Size discrete outputs
//  (relays, LEDs, opto drivers) from internal level requests and guarantees that
//  every output level is held for a minimum time, so the far-end filter never sees a
//  glitch. Sits between control logic and the output pins.
// PARAMETERS
//  Size           4        number of independent channels
//  ClockPeriod_ns 20       Clock period, ns
//  HoldPeriod_ns  500_000  minimum time an output level is held, ns
//  Ticks          4        hold-counter resolution; hold = Ticks enable pulses
//  InitValue      '1       [Size-1:0] value of O during and after reset
// PORTS
//  Clock    input   1     system clock, all logic on posedge
//  Reset_n  input   1     asynchronous, active-low reset
//  I        input   Size  requested output levels (synchronous to Clock)
//  O        output  Size  shaped output levels
//  Busy     output  Size  channel in HOLD (only with OUTPUT_SHAPER_BUSY_EN)
// BEHAVIOUR
//  - Prescale = HoldPeriod_ns / ClockPeriod_ns / Ticks (integer division).
//    Prescale > 1: Enable is a 1-clock pulse every Prescale clocks, free-running.
//    Prescale <= 1: Enable tied to 1. Ticks < 1: elaboration $error.
//  - Reset (Reset_n = 0, async): O = InitValue, all channels IDLE, counters 0,
//    prescaler count 0. Busy = 0. Release is synchronous to the next posedge.
//  - Per channel i, two states:
//    IDLE: if I[i] != O[i] at a posedge -> O[i] <= I[i], Cnt[i] <= Ticks, go HOLD.
//          Latency I -> O is exactly 1 clock. If I[i] == O[i], stay IDLE.
//    HOLD: I[i] ignored. On each Enable: Cnt[i] <= Cnt[i] - 1; when Cnt[i] == 1
//          at that Enable -> Cnt[i] <= 0, go IDLE. No Enable -> hold state.
//  - Hold quantisation: O[i] stable for at least (Ticks-1)*Prescale+1 and at most
//    Ticks*Prescale+1 clocks before the next change can be issued.
//  - On return to IDLE, I[i] is compared again on the next posedge; a request that
//    changed during HOLD and is still present is applied then (1 clock after IDLE).
//    A request that toggled and returned during HOLD produces no output change.
//  - Channels are fully independent; simultaneous requests on several channels are
//    all served in the same clock.
//  - Enable in the same cycle as an IDLE->HOLD transition is not counted for that
//    channel (counter loads Ticks, no decrement).
//  - Reset mid-HOLD: output returns to InitValue immediately; hold is abandoned.
//  - Cnt width = $clog2(Ticks+1); no wrap-around possible (never decremented at 0).
// CONFIGURATION
//  OUTPUT_SHAPER_BUSY_EN defined: port Busy present, Busy[i] = (state[i] == HOLD),
//    registered together with state, 0 in reset.
//  Not defined: port Busy absent; all other behaviour identical.
// STRUCTURE
//  - Package output_shaper_pkg: typedef enum logic {IDLE, HOLD} shaper_state_t;
//    function cnt_width(int ticks) returning $clog2(ticks+1).
//  - Sub-module hold_tick_gen #(N): Clock, Reset_n -> Pulse; counter 0..N-1, Pulse=1
//    when count == N-1, async reset to 0. Instantiated once, shared by all channels.
//  - Channel logic: generate loop over Size, one state reg + counter per channel.
// TESTING  (ClockPeriod_ns=20, HoldPeriod_ns=240, Ticks=4 -> Prescale=3, Size=4)
//  1 Reset: hold Reset_n=0, I=4'h0 -> O=4'hF, Busy=0; release -> 1 clock later O=4'h0.
//  2 Single change: I[0] 1->0 in IDLE -> O[0]=0 next clock; O[0] stays 0 for 10..13
//    clocks, then Busy[0]=0.
//  3 Change during HOLD: I[1] 1->0, 2 clocks later 0->1 -> O[1]=0 held full hold,
//    then O[1]=1 one clock after HOLD ends.
//  4 Short glitch during HOLD: I[2] 1->0, I[2] back to 0 after a 1-clock 1 pulse
//    inside HOLD -> O[2] single transition to 0, no second change.
//  5 Simultaneous: I 4'hF->4'h0 in one clock -> O=4'h0 next clock, all Busy=1, all
//    return IDLE on the same Enable.
//  6 Reset mid-HOLD: O[3]=0 in HOLD, pulse Reset_n low 1 ns -> O[3]=1 immediately,
//    Busy[3]=0; after release with I[3]=0 -> O[3]=0 next clock, fresh full hold.

Source files
------------

// File: rtl/output_shaper_pkg.sv
// ============================================================================
// output_shaper_pkg : shared types and helpers for output_hold_shaper
// Rev 1.0
// ============================================================================
`default_nettype none

package output_shaper_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } shaper_state_t;

    function automatic int cnt_width(input int ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage : output_shaper_pkg

`default_nettype wire

// File: rtl/hold_tick_gen.sv
// ============================================================================
// hold_tick_gen : free-running divider, one-clock Pulse every N clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module hold_tick_gen #(
    parameter int N = 2
) (
    input  logic Clock,
    input  logic Reset_n,
    output logic Pulse
);

    localparam int C_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [C_W-1:0] C_LAST = C_W'(N - 1);

    logic [C_W-1:0] r_count;
    logic           w_last;

    assign w_last = (r_count == C_LAST);
    assign Pulse  = w_last;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : hold_tick_gen

`default_nettype wire

// File: rtl/output_hold_shaper.sv
// ============================================================================
// output_hold_shaper : holds every output level for a minimum time
// Optional Busy port enabled by OUTPUT_SHAPER_BUSY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module output_hold_shaper
    import output_shaper_pkg::*;
#(
    parameter int              Size           = 4,
    parameter int              ClockPeriod_ns = 20,
    parameter int              HoldPeriod_ns  = 500_000,
    parameter int              Ticks          = 4,
    parameter logic [Size-1:0] InitValue      = '1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [Size-1:0] I,
    output logic [Size-1:0] O
`ifdef OUTPUT_SHAPER_BUSY_EN
    ,
    output logic [Size-1:0] Busy
`endif
);

    localparam int C_TICKS    = (Ticks < 1) ? 1 : Ticks;
    localparam int C_PRESCALE = HoldPeriod_ns / ClockPeriod_ns / C_TICKS;
    localparam int C_CNT_W    = cnt_width(C_TICKS);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(C_TICKS);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    logic w_enable;

    if (Ticks < 1) begin : g_ticks_check
        $error("output_hold_shaper: Ticks must be >= 1");
    end

    if (C_PRESCALE > 1) begin : g_prescaler
        hold_tick_gen #(
            .N (C_PRESCALE)
        ) u_tick_gen (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .Pulse   (w_enable)
        );
    end else begin : g_no_prescaler
        assign w_enable = 1'b1;
    end

    for (genvar gi = 0; gi < Size; gi++) begin : g_channel
        shaper_state_t      r_state;
        logic [C_CNT_W-1:0] r_cnt;
        logic               r_out;

        // Entering HOLD loads the full count; an Enable in that same cycle is not counted.
        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_out   <= InitValue[gi];
            end else begin
                case (r_state)
                    IDLE: begin
                        if (I[gi] != r_out) begin
                            r_out   <= I[gi];
                            r_cnt   <= C_CNT_LOAD;
                            r_state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (w_enable) begin
                            if (r_cnt == C_CNT_ONE) begin
                                r_cnt   <= '0;
                                r_state <= IDLE;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign O[gi] = r_out;

`ifdef OUTPUT_SHAPER_BUSY_EN
        assign Busy[gi] = (r_state == HOLD);
`endif
    end

endmodule : output_hold_shaper

`default_nettype wire

// File: tb/tb_output_hold_shaper.sv
// ============================================================================
// tb_output_hold_shaper : directed self-checking bench for output_hold_shaper
// Busy checks are active when OUTPUT_SHAPER_BUSY_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_output_hold_shaper;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] I;
    logic [3:0] O;
`ifdef OUTPUT_SHAPER_BUSY_EN
    logic [3:0] Busy;
`endif

    int total;
    int bad;
    int cur;

    output_hold_shaper #(
        .Size           (4),
        .ClockPeriod_ns (20),
        .HoldPeriod_ns  (240),
        .Ticks          (4),
        .InitValue      (4'hF)
    ) u_dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .I       (I),
        .O       (O)
`ifdef OUTPUT_SHAPER_BUSY_EN
        ,
        .Busy    (Busy)
`endif
    );

    initial Clock = 1'b0;
    always #10 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cur);
        end
    endtask

    // Advance to 1 time unit after posedge number k counted from reset release.
    task automatic goto_cycle(input int k);
        while (cur < k) begin
            @(posedge Clock);
            cur++;
        end
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cur     = 0;
        Reset_n = 1'b0;
        I       = 4'h0;

        // Reset: O forced to InitValue
        #15;
        check("reset_O", 32'(O), 32'hF);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("reset_Busy", 32'(Busy), 32'h0);
`endif
        #5 Reset_n = 1'b1;

        // Release: all channels follow I=0 one clock later; enables at 3,6,9,12
        goto_cycle(1);
        check("release_O", 32'(O), 32'h0);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("release_Busy", 32'(Busy), 32'hF);
`endif
        goto_cycle(2);
        I = 4'hF;
        goto_cycle(12);
        check("hold_end_O", 32'(O), 32'h0);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("hold_end_Busy", 32'(Busy), 32'h0);
`endif
        goto_cycle(13);
        check("simul_apply_O", 32'(O), 32'hF);

        // Simultaneous hold loaded at 13, enables 15,18,21,24 -> IDLE at 24
        goto_cycle(24);
        check("simul_hold_O", 32'(O), 32'hF);
        I = 4'b1010;
        goto_cycle(25);
        check("single_change_O", 32'(O), 32'hA);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("single_change_Busy", 32'(Busy), 32'h5);
`endif
        // ch0 request changes and persists; ch2 gets a 1-clock glitch
        I = 4'b1111;
        goto_cycle(26);
        check("glitch_in_O", 32'(O), 32'hA);
        I = 4'b1011;
        goto_cycle(30);
        check("mid_hold_O", 32'(O), 32'hA);
        goto_cycle(36);
        check("hold_min_O", 32'(O), 32'hA);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("hold_done_Busy", 32'(Busy), 32'h0);
`endif
        goto_cycle(37);
        check("late_apply_O", 32'(O), 32'hB);
        goto_cycle(38);
        check("no_glitch_O", 32'(O), 32'hB);

        // ch3 enters HOLD at 39, then reset pulse mid-hold
        I = 4'b0011;
        goto_cycle(39);
        check("ch3_hold_O", 32'(O), 32'h3);
        goto_cycle(40);
        #1 Reset_n = 1'b0;
        #1;
        check("mid_reset_O", 32'(O), 32'hF);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("mid_reset_Busy", 32'(Busy), 32'h0);
`endif
        Reset_n = 1'b1;
        #1;
        check("post_reset_O", 32'(O), 32'hF);

        // Prescaler restarted: load at 41, enables 43,46,49,52 -> IDLE at 52
        goto_cycle(41);
        check("reapply_O", 32'(O), 32'h3);
        I = 4'hF;
        goto_cycle(51);
`ifdef OUTPUT_SHAPER_BUSY_EN
        check("fresh_hold_Busy", 32'(Busy), 32'hC);
`endif
        goto_cycle(52);
        check("fresh_hold_O", 32'(O), 32'h3);
        goto_cycle(53);
        check("fresh_apply_O", 32'(O), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_output_hold_shaper

`default_nettype wire
